// File: rtl/bus_bridge_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_bridge_frame_decoder
// Description : Buffers {mode, addr, data} frames from the UART receiver in a
//               small FIFO, issues each one on a parallel request handshake
//               and returns read responses to the UART transmitter.
//               Optional feature macro: BRIDGE_RSP_TIMEOUT_EN (read-response
//               timeout that returns all-ones after TIMEOUT_CYCLES).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_bridge_frame_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx_ready,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]      rx_data,
    output logic                                req_valid,
    input  logic                                req_ready,
    output logic                                req_mode,
    output logic [ADDR_WIDTH-1:0]               req_addr,
    output logic [DATA_WIDTH-1:0]               req_wdata,
    input  logic                                rsp_valid,
    input  logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                tx_en,
    output logic [DATA_WIDTH-1:0]               tx_data,
    input  logic                                tx_busy,
    output logic                                overflow
);

    localparam int FRAME_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ISSUE    = 3'd1;
    localparam logic [2:0] c_WAIT_RSP = 3'd2;
    localparam logic [2:0] c_SEND     = 3'd3;
    localparam logic [2:0] c_WAIT_TX  = 3'd4;

    logic                  r_rx_ready_q;
    logic [FRAME_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_req_mode;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic                  w_push_edge;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_tx_capture;
    logic [DATA_WIDTH-1:0] w_tx_capture_data;
    logic [FRAME_W-1:0]    w_head;

    // One push per rising edge of rx_ready; a full FIFO still accepts when
    // the head leaves in the same cycle.
    assign w_push_edge  = rx_ready & ~r_rx_ready_q;
    assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = w_push_edge & (~w_fifo_full | w_pop);
    assign w_head       = r_mem[r_rd_ptr];

`ifdef BRIDGE_RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_expired;

    assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter: held at zero outside WAIT_RSP so it starts clean on entry.
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_WAIT_RSP)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`endif

    // Next-state and pop/capture decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_pop             = 1'b0;
        w_tx_capture      = 1'b0;
        w_tx_capture_data = rsp_rdata;
        case (r_state)
            c_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (req_ready) begin
                    w_state_nxt = r_req_mode ? c_IDLE : c_WAIT_RSP;
                end
            end
            c_WAIT_RSP: begin
                if (rsp_valid) begin
                    w_tx_capture = 1'b1;
                    w_state_nxt  = c_SEND;
                end
`ifdef BRIDGE_RSP_TIMEOUT_EN
                else if (w_to_expired) begin
                    w_tx_capture      = 1'b1;
                    w_tx_capture_data = '1;
                    w_state_nxt       = c_SEND;
                end
`endif
            end
            c_SEND: begin
                if (tx_busy) begin
                    w_state_nxt = c_WAIT_TX;
                end
            end
            c_WAIT_TX: begin
                if (!tx_busy) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame storage; contents need no reset since the count qualifies them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // FIFO pointers, occupancy, edge detector and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ready_q <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_ready_q <= rx_ready;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_edge && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Request fields load from the FIFO head; reads carry zero write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_mode  <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
        end else if (w_pop) begin
            r_req_mode  <= w_head[FRAME_W-1];
            r_req_addr  <= w_head[FRAME_W-2:DATA_WIDTH];
            r_req_wdata <= w_head[DATA_WIDTH-1:0] & {DATA_WIDTH{w_head[FRAME_W-1]}};
        end
    end

    // Response byte capture for the UART transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= '0;
        end else if (w_tx_capture) begin
            r_tx_data <= w_tx_capture_data;
        end
    end

    assign req_valid = (r_state == c_ISSUE);
    assign tx_en     = (r_state == c_SEND);
    assign req_mode  = r_req_mode;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign tx_data   = r_tx_data;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
